mem_dma: RTL and testbench
==========================

# mem_dma

Byte-granular DMA initiator that drives the single-port data memory's address, read-enable, write-enable and write-data lines, and samples its combinational read data. The controller programs it with a source, destination, length and mode. It then performs a forward block copy (read then write, per byte) or a constant fill (write only) without core involvement, and signals completion with a one-cycle pulse. It sits between the control unit and the data memory, sharing the memory port through the top-level mux when `Busy` is high.

## Interface
- `LEN_W`, default 8: width of the length and count fields; addresses are fixed at 8 bits.
- `CLK` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `Start` input 1: one-cycle command strobe, sampled only in IDLE.
- `Mode` input 1: 0 = COPY, 1 = FILL; latched on accepted `Start`.
- `SrcAddr` input 8: COPY source base; ignored for FILL.
- `DstAddr` input 8: destination base.
- `Len` input LEN_W: byte count; 0 means no transfer.
- `FillVal` input 8: FILL data; latched on `Start`.
- `Busy` output 1: high from the cycle after an accepted `Start` through the last write cycle.
- `Done` output 1: one-cycle completion pulse.
- `Count` output LEN_W: bytes written in the current or last command.
- `DataAddress` output 8: memory address.
- `ReadMem` output 1: memory read enable.
- `WriteMem` output 1: memory write enable; the write commits at the next `CLK` rising edge.
- `DataIn` output 8: memory write data.
- `DataOut` input 8: memory read data; valid only while `ReadMem` is high, otherwise Z.

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE
  - `Start` with `Len != 0`: latch all inputs and clear `Count`. Go to RD if COPY, or WR if FILL.
  - `Start` with `Len == 0`: go to FIN; no memory cycle is issued.
- RD (COPY only)
  - `ReadMem = 1`, `DataAddress = src_ptr`.
  - Capture `DataOut` into the byte buffer at the rising edge; go to WR.
- WR
  - `WriteMem = 1`, `DataAddress = dst_ptr`.
  - `DataIn` is the buffer (COPY) or the latched `FillVal` (FILL).
  - At the edge: increment `Count`; increment both pointers mod 256 (0xFF wraps to 0x00).
  - If `Count + 1 == len`, go to FIN. Otherwise go to RD (COPY) or stay in WR (FILL).
- FIN: `Done = 1`, `Busy = 0`; go to IDLE.
- Copy order is strictly ascending.
  - Overlapping regions with dst > src propagate already-written bytes. This is defined behaviour, not an error.
- `Start` outside IDLE is ignored; no queuing.
- `ReadMem` and `WriteMem` are never high in the same cycle. Both are low in IDLE and FIN.
- Memory outputs are decoded from registered state and pointers only; there is no combinational path from `Start`.

## Timing
- Reset (async assert, deasserted synchronously by the top level):
  - state = IDLE.
  - `Busy`, `Done`, `ReadMem`, `WriteMem` = 0.
  - `Count`, `DataAddress`, `DataIn` = 0.
  - Reset mid-transfer aborts immediately. Memory keeps the bytes already written; no `Done` pulse is produced.
- `Start` sampled at edge 0; first memory cycle is cycle 1.
- COPY of N bytes: cycles 1..2N alternate RD/WR; `Done` high in cycle 2N+1.
- FILL of N bytes: cycles 1..N are WR; `Done` high in cycle N+1.
- `Len == 0`: `Done` high in cycle 1.
- A new `Start` is accepted in the cycle after FIN at the earliest (back-to-back issue period = transfer + 2 cycles).
- `Count` is stable after `Done` until the next accepted `Start`.

## Structure
- `dma_pkg`:
  - `typedef enum logic [1:0] {IDLE, RD, WR, FIN} dma_state_t`.
  - `typedef enum logic {COPY, FILL} dma_mode_t`.
  - `localparam ADDR_W = 8`.
- Single module with one `always_ff` for state, pointers, buffer and count, plus one `always_comb` for output decode.
- No sub-module is needed. The two 8-bit wrapping pointers are plain registers.

## Test plan
- COPY src=0x10, dst=0x80, Len=3, mem[0x10..0x12] = 11,22,33:
  - mem[0x80..0x82] = 11,22,33.
  - `ReadMem` high in cycles 1, 3, 5; `WriteMem` high in cycles 2, 4, 6; `Done` in cycle 7; `Count` = 3.
- FILL dst=0xFE, Len=4, FillVal=0xA5:
  - writes to 0xFE, 0xFF, 0x00, 0x01 (wrap).
  - `Done` in cycle 5; mem[0x02] unchanged.
- `Len` = 0 with either mode: no `ReadMem`/`WriteMem` pulse, `Done` in cycle 1, `Count` = 0.
- Second `Start` pulsed in cycle 2 of a 3-byte COPY: ignored, with exactly one `Done`.
  - A `Start` in the cycle after `Done` is accepted.
- Overlapping COPY src=0x20, dst=0x21, Len=3, mem[0x20..0x23] = 1,2,3,4: mem[0x21..0x23] = 1,1,1.
- `reset_n` low in cycle 3 of a 4-byte FILL:
  - all outputs 0 asynchronously; only the first 2 bytes are written.
  - no `Done`; a new `Start` is accepted after reset release.

Source files
------------

// File: rtl/mem_dma_pkg.sv
// Shared types for the byte-granular memory DMA engine.
// State and mode encodings plus the fixed memory address width.
package dma_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} dma_state_t;
  typedef enum logic {COPY, FILL} dma_mode_t;

  localparam int ADDR_W = 8;

endpackage

// File: rtl/mem_dma_if.sv
// Single-port data memory bus: the DMA drives address/enables/write data,
// the memory returns combinational read data while ReadMem is high.
interface mem_dma_if;
  import dma_pkg::*;

  logic [ADDR_W-1:0] DataAddress;
  logic              ReadMem;
  logic              WriteMem;
  logic [7:0]        DataIn;
  logic [7:0]        DataOut;

  modport master (
    output DataAddress,
    output ReadMem,
    output WriteMem,
    output DataIn,
    input  DataOut
  );

  modport slave (
    input  DataAddress,
    input  ReadMem,
    input  WriteMem,
    input  DataIn,
    output DataOut
  );

endinterface

// File: rtl/mem_dma.sv
// Byte DMA: forward block copy (read then write per byte) or constant fill.
// COPY N bytes takes 2N cycles, FILL N takes N; Done pulses one cycle after the last write.
module mem_dma
  import dma_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              Start,
  input  logic              Mode,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [LEN_W-1:0]  Len,
  input  logic [7:0]        FillVal,
  output logic              Busy,
  output logic              Done,
  output logic [LEN_W-1:0]  Count,
  mem_dma_if.master         mem
);

  dma_state_t        state;
  dma_mode_t         mode_q;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [7:0]        byte_buf;
  logic [7:0]        fill_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_nxt;

  assign count_nxt = Count + LEN_W'(1);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      mode_q   <= COPY;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      byte_buf <= '0;
      fill_q   <= '0;
      len_q    <= '0;
      Count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            mode_q  <= dma_mode_t'(Mode);
            src_ptr <= SrcAddr;
            dst_ptr <= DstAddr;
            fill_q  <= FillVal;
            len_q   <= Len;
            Count   <= '0;
            if (Len == '0)
              state <= FIN;
            else if (dma_mode_t'(Mode) == FILL)
              state <= WR;
            else
              state <= RD;
          end
        end
        RD: begin
          byte_buf <= mem.DataOut;
          state    <= WR;
        end
        WR: begin
          Count   <= count_nxt;
          src_ptr <= src_ptr + 8'd1;
          dst_ptr <= dst_ptr + 8'd1;
          if (count_nxt == len_q)
            state <= FIN;
          else if (mode_q == FILL)
            state <= WR;
          else
            state <= RD;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side signals depend only on registered state, never on Start.
  always_comb begin
    mem.DataAddress = '0;
    mem.ReadMem     = 1'b0;
    mem.WriteMem    = 1'b0;
    mem.DataIn      = '0;
    Busy            = 1'b0;
    Done            = 1'b0;
    case (state)
      RD: begin
        mem.ReadMem     = 1'b1;
        mem.DataAddress = src_ptr;
        Busy            = 1'b1;
      end
      WR: begin
        mem.WriteMem    = 1'b1;
        mem.DataAddress = dst_ptr;
        mem.DataIn      = (mode_q == FILL) ? fill_q : byte_buf;
        Busy            = 1'b1;
      end
      FIN: Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: table of commands with a memory/write scoreboard,
// plus hand sequences for reset state and mid-transfer reset abort.
module tb_mem_dma;
  import dma_pkg::*;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic       Start;
  logic       Mode;
  logic [7:0] SrcAddr;
  logic [7:0] DstAddr;
  logic [7:0] Len;
  logic [7:0] FillVal;
  logic       Busy;
  logic       Done;
  logic [7:0] Count;

  int checks   = 0;
  int failures = 0;

  mem_dma_if mif ();

  mem_dma #(.LEN_W(8)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .Start   (Start),
    .Mode    (Mode),
    .SrcAddr (SrcAddr),
    .DstAddr (DstAddr),
    .Len     (Len),
    .FillVal (FillVal),
    .Busy    (Busy),
    .Done    (Done),
    .Count   (Count),
    .mem     (mif.master)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [256];
  always @(posedge CLK) if (mif.WriteMem) mem[mif.DataAddress] <= mif.DataIn;
  assign mif.DataOut = mif.ReadMem ? mem[mif.DataAddress] : 8'hzz;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    string name;
    bit    mode;
    int    src;
    int    dst;
    int    len;
    int    fill;
    int    ghost;
    int    exp_done;
    int    exp_count;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    logic [7:0] em [256];
    logic [7:0] a8, d8;
    wr_t e;
    int dones;
    int bad;
    bit exp_rd, exp_wr;
    for (int i = 0; i < 256; i++) em[i] = mem[i];
    for (int i = 0; i < v.len; i++) begin
      a8 = 8'(v.dst + i);
      d8 = v.mode ? 8'(v.fill) : em[8'(v.src + i)];
      em[a8] = d8;
      wq.push_back({a8, d8});
    end
    Start   = 1'b1;
    Mode    = v.mode;
    SrcAddr = 8'(v.src);
    DstAddr = 8'(v.dst);
    Len     = 8'(v.len);
    FillVal = 8'(v.fill);
    dones   = 0;
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      @(negedge CLK);
      if (c == 1) Start = 1'b0;
      if (v.ghost != 0 && c == v.ghost) begin
        Start   = 1'b1;
        Mode    = ~v.mode;
        SrcAddr = 8'h00;
        DstAddr = 8'hC0;
        Len     = 8'd5;
        FillVal = 8'hEE;
      end
      if (v.ghost != 0 && c == v.ghost + 1) Start = 1'b0;
      if (v.mode == 1'b0) begin
        exp_rd = (c <= 2 * v.len) && (c % 2 == 1);
        exp_wr = (c <= 2 * v.len) && (c % 2 == 0);
      end else begin
        exp_rd = 1'b0;
        exp_wr = (c <= v.len);
      end
      chk($sformatf("%s.c%0d.ReadMem", v.name, c), mif.ReadMem, exp_rd);
      chk($sformatf("%s.c%0d.WriteMem", v.name, c), mif.WriteMem, exp_wr);
      chk($sformatf("%s.c%0d.Done", v.name, c), Done, c == v.exp_done);
      chk($sformatf("%s.c%0d.Busy", v.name, c), Busy, c < v.exp_done);
      if (mif.WriteMem) begin
        if (wq.size() == 0) begin
          chk($sformatf("%s.c%0d.unexpected_write", v.name, c), 1, 0);
        end else begin
          e = wq.pop_front();
          chk($sformatf("%s.c%0d.wr_addr", v.name, c), mif.DataAddress, e.a);
          chk($sformatf("%s.c%0d.wr_data", v.name, c), mif.DataIn, e.d);
        end
      end
      if (Done) dones++;
    end
    chk($sformatf("%s.done_pulses", v.name), dones, 1);
    chk($sformatf("%s.Count", v.name), Count, v.exp_count);
    chk($sformatf("%s.writes_left", v.name), wq.size(), 0);
    wq.delete();
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== em[i]) bad++;
    chk($sformatf("%s.mem_bytes_wrong", v.name), bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    vec_t v;
    reset_n = 1'b0;
    Start   = 1'b0;
    Mode    = 1'b0;
    SrcAddr = '0;
    DstAddr = '0;
    Len     = '0;
    FillVal = '0;
    for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    #1;
    mem[8'h10] <= 8'h11; mem[8'h11] <= 8'h22; mem[8'h12] <= 8'h33;
    mem[8'h20] <= 8'd1;  mem[8'h21] <= 8'd2;  mem[8'h22] <= 8'd3; mem[8'h23] <= 8'd4;
    #1;
    chk("reset.Busy", Busy, 0);
    chk("reset.Done", Done, 0);
    chk("reset.Count", Count, 0);
    chk("reset.ReadMem", mif.ReadMem, 0);
    chk("reset.WriteMem", mif.WriteMem, 0);
    chk("reset.DataAddress", mif.DataAddress, 0);
    chk("reset.DataIn", mif.DataIn, 0);
    @(negedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);

    vecs[0] = '{"copy3",        1'b0, 'h10, 'h80, 3, 'h00, 0, 7, 3};
    vecs[1] = '{"fill_wrap",    1'b1, 'h00, 'hFE, 4, 'hA5, 0, 5, 4};
    vecs[2] = '{"copy_len0",    1'b0, 'h30, 'h90, 0, 'h00, 0, 1, 0};
    vecs[3] = '{"fill_len0",    1'b1, 'h00, 'h91, 0, 'h77, 0, 1, 0};
    vecs[4] = '{"overlap",      1'b0, 'h20, 'h21, 3, 'h00, 0, 7, 3};
    vecs[5] = '{"ghost_start",  1'b0, 'h50, 'hA0, 3, 'h00, 2, 7, 3};
    vecs[6] = '{"copy_srcwrap", 1'b0, 'hFF, 'h40, 2, 'h00, 0, 5, 2};
    for (int k = 0; k < 7; k++) run_cmd(vecs[k]);

    chk("copy3.mem80", mem[8'h80], 8'h11);
    chk("copy3.mem81", mem[8'h81], 8'h22);
    chk("copy3.mem82", mem[8'h82], 8'h33);
    chk("fill.memFE", mem[8'hFE], 8'hA5);
    chk("fill.memFF", mem[8'hFF], 8'hA5);
    chk("fill.mem00", mem[8'h00], 8'hA5);
    chk("fill.mem01", mem[8'h01], 8'hA5);
    chk("fill.mem02_untouched", mem[8'h02], 8'h58);
    chk("overlap.mem21", mem[8'h21], 8'd1);
    chk("overlap.mem22", mem[8'h22], 8'd1);
    chk("overlap.mem23", mem[8'h23], 8'd1);
    chk("srcwrap.mem40", mem[8'h40], 8'hA5);
    chk("srcwrap.mem41", mem[8'h41], 8'hA5);

    // Mid-transfer reset on a 4-byte fill: two writes land, then abort.
    Start = 1'b1; Mode = 1'b1; DstAddr = 8'h60; Len = 8'd4; FillVal = 8'h3C;
    @(negedge CLK);
    Start = 1'b0;
    chk("rst.c1.WriteMem", mif.WriteMem, 1);
    chk("rst.c1.addr", mif.DataAddress, 8'h60);
    @(negedge CLK);
    chk("rst.c2.addr", mif.DataAddress, 8'h61);
    @(negedge CLK);
    chk("rst.c3.WriteMem_before", mif.WriteMem, 1);
    reset_n = 1'b0;
    #1;
    chk("rst.async.Busy", Busy, 0);
    chk("rst.async.Done", Done, 0);
    chk("rst.async.Count", Count, 0);
    chk("rst.async.ReadMem", mif.ReadMem, 0);
    chk("rst.async.WriteMem", mif.WriteMem, 0);
    chk("rst.async.DataAddress", mif.DataAddress, 0);
    chk("rst.async.DataIn", mif.DataIn, 0);
    @(negedge CLK);
    @(negedge CLK);
    reset_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (Done || mif.WriteMem || mif.ReadMem) dones++;
    end
    chk("rst.no_activity_after_abort", dones, 0);
    chk("rst.mem60", mem[8'h60], 8'h3C);
    chk("rst.mem61", mem[8'h61], 8'h3C);
    chk("rst.mem62_untouched", mem[8'h62], 8'h38);
    chk("rst.mem63_untouched", mem[8'h63], 8'h39);

    v = '{"after_reset", 1'b1, 'h00, 'h62, 2, 'hC3, 0, 3, 2};
    run_cmd(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
